decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction decode stage that sits between instruction fetch and the execute/register-read stage. It accepts raw instruction words over a valid/ready handshake, splits them into condition, opcode, register and operand fields, and evaluates the condition against the current flags. It selects register or immediate operand mode and flags illegal opcodes. A two-entry skid buffer gives full throughput with a registered `in_ready`, and a flush input discards in-flight instructions on a branch.

## Interface

- `INST_W`, 16, instruction width; legal values 16 or 32
- `OP_W`, 4, opcode field width
- `REG_AW`, 3, register-address field width
- `NUM_OPS`, 12, opcodes `>= NUM_OPS` are illegal
- `CNT_W`, 16, decoded-instruction counter width
- Derived: `REM_W = INST_W-2-OP_W-2*REG_AW` (must be `>= REG_AW+1`); `SH_W = REM_W-REG_AW`

- `clk  in  1  clock; all state updates on the rising edge`
- `rst_n  in  1  reset; asynchronous, active-low`
- `flush  in  1  synchronous discard of all buffered instructions`
- `in_valid  in  1  inst presented`
- `in_ready  out  1  stage can accept; registered`
- `inst  in  INST_W  raw instruction`
- `flag_z  in  1  zero flag, sampled on accept`
- `flag_n  in  1  negative flag, sampled on accept`
- `out_valid  out  1  decoded word valid`
- `out_ready  in  1  downstream accepts`
- `cond  out  2  condition field`
- `op_code  out  OP_W  opcode`
- `dest_reg  out  REG_AW  destination register`
- `src_reg_1  out  REG_AW  first source register`
- `src_reg_2  out  REG_AW  second source register; 0 in immediate mode`
- `shift  out  SH_W  shift amount; 0 in immediate mode`
- `imm  out  INST_W  sign-extended immediate; 0 in register mode`
- `imm_mode  out  1  op_code MSB set`
- `exec  out  1  condition passed`
- `illegal  out  1  op_code >= NUM_OPS`
- `inst_count  out  CNT_W  output handshakes since reset; wraps`

## Operation

- Field layout, MSB first: `cond[2]`, `op_code[OP_W]`, `dest_reg[REG_AW]`, `src_reg_1[REG_AW]`, `rem[REM_W]`.
- Register mode (`op_code` MSB = 0): `src_reg_2 = rem[REM_W-1 -: REG_AW]`, `shift = rem[SH_W-1:0]`, `imm = 0`.
- Immediate mode (`op_code` MSB = 1): `imm = sign-extend(rem)` to `INST_W`, `src_reg_2 = 0`, `shift = 0`.
- Condition evaluation uses the flags sampled in the accept cycle:
  - `cond = 0`: always
  - `cond = 1`: Z set
  - `cond = 2`: Z clear
  - `cond = 3`: N set
- `illegal` instructions still pass downstream, with `exec` forced to 0.
- Decoding happens on accept; decoded fields are stored in the output register and, when needed, the skid register.
- States:
  - EMPTY: output register and skid register both empty.
  - ONE: output register full.
  - TWO: output register and skid register both full.
- Transitions:
  - EMPTY → ONE on accept.
  - ONE → ONE on accept with output handshake, or with neither event.
  - ONE → TWO on accept without output handshake.
  - ONE → EMPTY on output handshake without accept.
  - TWO → ONE on output handshake; the skid entry moves to the output register.
- `in_ready = (state != TWO)`. Registered; no combinational path from `out_ready`.
- `flush` has priority over everything: next state is EMPTY, an accept in the same cycle is dropped, and an output handshake in the same cycle is not counted.
- `inst_count` increments on `out_valid & out_ready`, modulo `2^CNT_W`.

## Timing

- Reset (async assert, sync release): state EMPTY; `in_ready = 1`, `out_valid = 0`; all field outputs, `exec`, `illegal`, `imm_mode` and `inst_count` are 0.
- Latency: accept in cycle N gives `out_valid` in cycle N+1.
- Throughput: one instruction per cycle while `out_ready = 1`.
- Output fields are held stable while `out_valid & !out_ready`.
- `in_ready` drops the cycle after entering TWO and rises the cycle after leaving it.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- After `flush`: `out_valid = 0` next cycle, `in_ready = 1`.

## Test plan

- Default params, `inst = 16'hAAAA`, `flag_z = 0` → next cycle: `cond = 2`, `op_code = 10`, `imm_mode = 1`, `dest_reg = 5`, `src_reg_1 = 2`, `imm = 16'hFFFA`, `src_reg_2 = 0`, `exec = 1`, `illegal = 0`.
- `inst = 16'h1234` → `cond = 0`, `op_code = 4`, `dest_reg = 4`, `src_reg_1 = 3`, `src_reg_2 = 2`, `shift = 0`, `imm = 0`, `exec = 1`.
- `inst = 16'h3C00` → `op_code = 15`, `illegal = 1`, `exec = 0`, `out_valid = 1`.
- Backpressure: stream `16'h1234`, `16'hAAAA`, `16'h3C00` with `out_ready = 0` → `in_ready` low after 2 accepts. Then `out_ready = 1` → the three words emerge in order, `inst_count = 3`.
- `flush` asserted in TWO together with `in_valid` → `out_valid = 0` next cycle, `in_ready = 1`, `inst_count` unchanged, nothing later emitted.
- `CNT_W = 2`, 5 handshakes → `inst_count = 1`. `INST_W = 32` run: check `REM_W = 16`, `SH_W = 13`, and 16-bit immediate sign extension.

Source files
------------

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered instruction decode stage with two-entry skid buffer
module decode_stage #(
  parameter int unsigned INST_W  = 16,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned REG_AW  = 3,
  parameter int unsigned NUM_OPS = 12,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [INST_W-1:0]                     inst,
  input  logic                                  flag_z,
  input  logic                                  flag_n,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [1:0]                            cond,
  output logic [OP_W-1:0]                       op_code,
  output logic [REG_AW-1:0]                     dest_reg,
  output logic [REG_AW-1:0]                     src_reg_1,
  output logic [REG_AW-1:0]                     src_reg_2,
  output logic [INST_W-2-OP_W-3*REG_AW-1:0]     shift,
  output logic [INST_W-1:0]                     imm,
  output logic                                  imm_mode,
  output logic                                  exec,
  output logic                                  illegal,
  output logic [CNT_W-1:0]                      inst_count
);

  localparam int unsigned REM_W = INST_W - 2 - OP_W - 2 * REG_AW;
  localparam int unsigned SH_W  = REM_W - REG_AW;

  typedef struct packed {
    logic [1:0]        cond;
    logic [OP_W-1:0]   op_code;
    logic [REG_AW-1:0] dest_reg;
    logic [REG_AW-1:0] src_reg_1;
    logic [REG_AW-1:0] src_reg_2;
    logic [SH_W-1:0]   shift;
    logic [INST_W-1:0] imm;
    logic              imm_mode;
    logic              exec;
    logic              illegal;
  } dec_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state;
  dec_t             dec;
  dec_t             out_r;
  dec_t             skid_r;
  logic [REM_W-1:0] rem;
  logic             cond_ok;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             handshake;

  always_comb begin
    dec           = '0;
    cond_ok       = 1'b0;
    rem           = inst[REM_W-1:0];
    dec.cond      = inst[INST_W-1 -: 2];
    dec.op_code   = inst[INST_W-3 -: OP_W];
    dec.dest_reg  = inst[INST_W-3-OP_W -: REG_AW];
    dec.src_reg_1 = inst[INST_W-3-OP_W-REG_AW -: REG_AW];
    dec.imm_mode  = dec.op_code[OP_W-1];
    if (dec.imm_mode) begin
      dec.imm = {{(INST_W-REM_W){rem[REM_W-1]}}, rem};
    end else begin
      dec.src_reg_2 = rem[REM_W-1 -: REG_AW];
      dec.shift     = rem[SH_W-1:0];
    end
    dec.illegal = (32'(dec.op_code) >= NUM_OPS);
    case (dec.cond)
      2'd0:    cond_ok = 1'b1;
      2'd1:    cond_ok = flag_z;
      2'd2:    cond_ok = ~flag_z;
      default: cond_ok = flag_n;
    endcase
    dec.exec = cond_ok & ~dec.illegal;
  end

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;

  // in_ready and out_valid are kept as registered mirrors of the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_r     <= '0;
      skid_r    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (handshake) cnt <= cnt + 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            out_r     <= dec;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && handshake) begin
            out_r <= dec;
          end else if (accept) begin
            skid_r   <= dec;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (handshake) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (handshake) begin
            out_r    <= skid_r;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cond       = out_r.cond;
  assign op_code    = out_r.op_code;
  assign dest_reg   = out_r.dest_reg;
  assign src_reg_1  = out_r.src_reg_1;
  assign src_reg_2  = out_r.src_reg_2;
  assign shift      = out_r.shift;
  assign imm        = out_r.imm;
  assign imm_mode   = out_r.imm_mode;
  assign exec       = out_r.exec;
  assign illegal    = out_r.illegal;
  assign inst_count = cnt;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, flag_z, flag_n, out_ready;
  logic [15:0] inst;
  logic        a_in_ready, a_out_valid, a_imm_mode, a_exec, a_illegal;
  logic [1:0]  a_cond;
  logic [3:0]  a_op_code;
  logic [2:0]  a_dest, a_src1, a_src2;
  logic [0:0]  a_shift;
  logic [15:0] a_imm, a_count;

  logic        b_flush, b_in_valid, b_out_ready;
  logic [31:0] b_inst;
  logic        b_in_ready, b_out_valid, b_imm_mode, b_exec, b_illegal;
  logic [1:0]  b_cond, b_count;
  logic [7:0]  b_op_code;
  logic [2:0]  b_dest, b_src1, b_src2;
  logic [12:0] b_shift;
  logic [31:0] b_imm;

  decode_stage dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .inst(inst), .flag_z(flag_z), .flag_n(flag_n), .out_valid(a_out_valid), .out_ready(out_ready),
    .cond(a_cond), .op_code(a_op_code), .dest_reg(a_dest), .src_reg_1(a_src1), .src_reg_2(a_src2),
    .shift(a_shift), .imm(a_imm), .imm_mode(a_imm_mode), .exec(a_exec), .illegal(a_illegal),
    .inst_count(a_count)
  );

  decode_stage #(.INST_W(32), .OP_W(8), .REG_AW(3), .NUM_OPS(200), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .inst(b_inst), .flag_z(flag_z), .flag_n(flag_n), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .cond(b_cond), .op_code(b_op_code), .dest_reg(b_dest), .src_reg_1(b_src1), .src_reg_2(b_src2),
    .shift(b_shift), .imm(b_imm), .imm_mode(b_imm_mode), .exec(b_exec), .illegal(b_illegal),
    .inst_count(b_count)
  );

  typedef struct {
    longint unsigned cond, op, dest, src1, src2, shift, imm, imm_mode, exec, illegal;
  } dec_t;

  int tests = 0;
  int failed = 0;
  dec_t qa[$];
  longint unsigned cnt_a = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic dec_t model(longint unsigned iw, longint unsigned ow, longint unsigned aw,
                                 longint unsigned nops, logic [31:0] w, bit z, bit n);
    dec_t d;
    longint unsigned remw = iw - 2 - ow - 2 * aw;
    longint unsigned shw  = remw - aw;
    longint unsigned word = longint'(w);
    longint unsigned rem  = word % (64'd1 << remw);
    bit passed;
    d.cond     = word >> (iw - 2);
    d.op       = (word >> (iw - 2 - ow)) % (64'd1 << ow);
    d.dest     = (word >> (remw + aw)) % (64'd1 << aw);
    d.src1     = (word >> remw) % (64'd1 << aw);
    d.imm_mode = (d.op >= (64'd1 << (ow - 1))) ? 1 : 0;
    d.illegal  = (d.op >= nops) ? 1 : 0;
    if (d.imm_mode == 1) begin
      d.src2  = 0;
      d.shift = 0;
      d.imm   = (rem >= (64'd1 << (remw - 1))) ? (64'd1 << iw) - (64'd1 << remw) + rem : rem;
    end else begin
      d.src2  = rem >> shw;
      d.shift = rem % (64'd1 << shw);
      d.imm   = 0;
    end
    case (d.cond)
      0: passed = 1;
      1: passed = z;
      2: passed = !z;
      default: passed = n;
    endcase
    d.exec = (passed && d.illegal == 0) ? 1 : 0;
    return d;
  endfunction

  task automatic fields_a(dec_t e);
    check_eq("a_cond", a_cond, e.cond);
    check_eq("a_op_code", a_op_code, e.op);
    check_eq("a_dest", a_dest, e.dest);
    check_eq("a_src1", a_src1, e.src1);
    check_eq("a_src2", a_src2, e.src2);
    check_eq("a_shift", a_shift, e.shift);
    check_eq("a_imm", a_imm, e.imm);
    check_eq("a_imm_mode", a_imm_mode, e.imm_mode);
    check_eq("a_exec", a_exec, e.exec);
    check_eq("a_illegal", a_illegal, e.illegal);
  endtask

  // one cycle on dut_a: drive, check at negedge against model, advance model
  task automatic step_a(bit v, logic [15:0] w, bit z, bit n, bit ordy, bit fl);
    bit rdy;
    in_valid = v; inst = w; flag_z = z; flag_n = n; out_ready = ordy; flush = fl;
    @(negedge clk);
    check_eq("a_in_ready", a_in_ready, qa.size() < 2);
    check_eq("a_out_valid", a_out_valid, qa.size() > 0);
    check_eq("a_count", a_count, cnt_a);
    if (qa.size() > 0) fields_a(qa[0]);
    if (fl) begin
      qa.delete();
    end else begin
      rdy = qa.size() < 2;
      if (ordy && qa.size() > 0) begin
        void'(qa.pop_front());
        cnt_a = (cnt_a + 1) % 65536;
      end
      if (v && rdy) qa.push_back(model(16, 4, 3, 12, {16'h0, w}, z, n));
    end
    @(posedge clk); #1;
  endtask

  task automatic step_b(bit v, logic [31:0] w);
    dec_t e;
    b_in_valid = v; b_inst = w;
    @(posedge clk); #1;
    if (v) begin
      e = model(32, 8, 3, 200, w, flag_z, flag_n);
      check_eq("b_out_valid", b_out_valid, 1);
      check_eq("b_op_code", b_op_code, e.op);
      check_eq("b_src2", b_src2, e.src2);
      check_eq("b_shift", b_shift, e.shift);
      check_eq("b_imm", b_imm, e.imm);
      check_eq("b_exec", b_exec, e.exec);
      check_eq("b_illegal", b_illegal, e.illegal);
    end
  endtask

  initial begin
    longint unsigned base;
    rst_n = 0; flush = 0; in_valid = 0; inst = '0; flag_z = 0; flag_n = 0; out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_inst = '0; b_out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", a_in_ready, 1);
    check_eq("rst_out_valid", a_out_valid, 0);
    check_eq("rst_fields", {a_cond, a_op_code, a_dest, a_src1, a_src2, a_shift, a_imm}, 0);
    check_eq("rst_flags", {a_imm_mode, a_exec, a_illegal}, 0);
    check_eq("rst_count", a_count, 0);
    @(posedge clk); #1 rst_n = 1;

    step_a(1, 16'hAAAA, 0, 0, 1, 0);
    check_eq("aaaa_cond", a_cond, 2);
    check_eq("aaaa_op", a_op_code, 10);
    check_eq("aaaa_dest", a_dest, 5);
    check_eq("aaaa_src1", a_src1, 2);
    check_eq("aaaa_imm", a_imm, 16'hFFFA);
    check_eq("aaaa_mode_exec", {a_imm_mode, a_exec, a_illegal, a_src2}, {3'b110, 3'd0});
    step_a(1, 16'h1234, 0, 0, 1, 0);
    check_eq("1234_fields", {a_cond, a_op_code, a_dest, a_src1, a_src2, a_shift}, {2'd0, 4'd4, 3'd4, 3'd3, 3'd2, 1'b0});
    check_eq("1234_imm_exec", {a_imm, a_exec}, {16'h0, 1'b1});
    step_a(1, 16'h3C00, 0, 0, 1, 0);
    check_eq("3c00_op", a_op_code, 15);
    check_eq("3c00_flags", {a_out_valid, a_illegal, a_exec}, 3'b110);
    repeat (2) step_a(0, 16'h0, 0, 0, 1, 0);

    base = cnt_a;
    step_a(1, 16'h1234, 0, 0, 0, 0);
    step_a(1, 16'hAAAA, 0, 0, 0, 0);
    check_eq("bp_in_ready_low", a_in_ready, 0);
    step_a(1, 16'h3C00, 0, 0, 0, 0);
    step_a(1, 16'h3C00, 0, 0, 1, 0);
    step_a(1, 16'h3C00, 0, 0, 1, 0);
    repeat (2) step_a(0, 16'h0, 0, 0, 1, 0);
    check_eq("bp_count", a_count, base + 3);

    base = cnt_a;
    step_a(1, 16'h1234, 0, 0, 0, 0);
    step_a(1, 16'hAAAA, 0, 0, 0, 0);
    step_a(1, 16'h3C00, 0, 0, 1, 1);
    check_eq("flush_out_valid", a_out_valid, 0);
    check_eq("flush_in_ready", a_in_ready, 1);
    check_eq("flush_count", a_count, base);
    repeat (3) step_a(0, 16'h0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++)
      step_a($urandom_range(0, 1), 16'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 3);

    step_a(1, 16'h1234, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    check_eq("async_rst_out_valid", a_out_valid, 0);
    check_eq("async_rst_in_ready", a_in_ready, 1);
    check_eq("async_rst_count", a_count, 0);
    @(posedge clk); #1 rst_n = 1;
    qa.delete(); cnt_a = 0;
    in_valid = 0; out_ready = 1;

    check_eq("b_rst_count", b_count, 0);
    step_b(1, 32'h2000_8001);
    check_eq("b_imm_sext", b_imm, 32'hFFFF_8001);
    step_b(1, 32'h0000_A005);
    check_eq("b_reg_src2", b_src2, 5);
    check_eq("b_reg_shift", b_shift, 13'h0005);
    for (int i = 0; i < 3; i++) step_b(1, $urandom);
    step_b(0, 32'h0);
    check_eq("b_count_wrap", b_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
